// File: rtl/shift_seq_pkg.sv
// Shared mode encoding and step/seed helpers for the shift-sequence counter.
// Helpers work on a MAXW-wide vector; callers pass the live width and truncate.
package shift_seq_pkg;

    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_RING    = 1'b1;
    localparam int   MAXW         = 64;

    function automatic logic [MAXW-1:0] seed_value(input logic mode);
        logic [MAXW-1:0] s;
        s    = '0;
        s[0] = (mode == MODE_RING);
        return s;
    endfunction

    // Johnson feeds back the inverted end bit, ring feeds it back unchanged.
    function automatic logic [MAXW-1:0] next_value(input logic mode, input logic dir,
                                                   input logic [MAXW-1:0] q, input int w);
        logic [MAXW-1:0] mask;
        logic [MAXW-1:0] r;
        logic            twist;
        twist = (mode == MODE_JOHNSON);
        mask  = (MAXW'(1) << w) - MAXW'(1);
        if (dir) begin
            r    = (q << 1) & mask;
            r[0] = q[w-1] ^ twist;
        end else begin
            r      = (q & mask) >> 1;
            r[w-1] = q[0] ^ twist;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_seq_decode.sv
// Combinational legality check and phase index for a Johnson or ring value.
module shift_seq_decode
    import shift_seq_pkg::*;
#(
    parameter  int W  = 4,
    localparam int PW = $clog2(2*W)
) (
    input  logic          mode,
    input  logic [W-1:0]  value,
    output logic          legal,
    output logic [PW-1:0] index
);

    logic [W-1:0] inv;

    always_comb begin
        int pop;
        int pos;
        inv = ~value;
        pop = 0;
        pos = 0;
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                pop = pop + 1;
                pos = i;
            end
        end
        if (mode == MODE_RING) begin
            legal = (pop == 1);
            index = PW'(pos);
        end else begin
            // Ones run anchored at bit 0 (low fill) or at bit W-1 (high fill).
            legal = ((value & (value + W'(1))) == '0) || ((inv & (inv + W'(1))) == '0);
            index = (value[0] || (value == '0)) ? PW'(pop) : PW'(2*W - pop);
        end
    end

endmodule

// File: rtl/shift_seq_counter.sv
// Parametrised Johnson / one-hot ring sequence counter with load, direction,
// phase index, wrap pulse and self-correction of upset states.
module shift_seq_counter
    import shift_seq_pkg::*;
#(
    parameter int W  = 4,
    parameter int PW = $clog2(2*W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          dir,
    input  logic          mode,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    output logic [W-1:0]  q,
    output logic [PW-1:0] phase,
    output logic          wrap,
    output logic          err
);

    logic          mode_q;
    logic          q_legal;
    logic          ld_legal;
    logic [PW-1:0] q_idx;
    logic [PW-1:0] ld_idx;
    logic [PW-1:0] idx_last;
    logic [W-1:0]  q_step;
    logic [W-1:0]  seed_in;
    logic [W-1:0]  seed_cur;

    shift_seq_decode #(.W(W)) u_dec_q (
        .mode  (mode_q),
        .value (q),
        .legal (q_legal),
        .index (q_idx)
    );

    shift_seq_decode #(.W(W)) u_dec_ld (
        .mode  (mode_q),
        .value (load_val),
        .legal (ld_legal),
        .index (ld_idx)
    );

    assign idx_last = (mode_q == MODE_RING) ? PW'(W - 1) : PW'(2*W - 1);
    assign seed_in  = W'(seed_value(mode));
    assign seed_cur = W'(seed_value(mode_q));
    assign q_step   = W'(next_value(mode_q, dir, MAXW'(q), W));

    // Stepping uses the index decoded from q, which equals phase whenever q is legal.
    always_ff @(posedge clk) begin
        wrap <= 1'b0;
        err  <= 1'b0;
        if (reset || (mode != mode_q)) begin
            mode_q <= mode;
            q      <= seed_in;
            phase  <= '0;
        end else if (!q_legal) begin
            q     <= seed_cur;
            phase <= '0;
            err   <= 1'b1;
        end else if (load) begin
            if (ld_legal) begin
                q     <= load_val;
                phase <= ld_idx;
            end else begin
                err <= 1'b1;
            end
        end else if (en) begin
            q <= q_step;
            if (dir) begin
                phase <= (q_idx == idx_last) ? '0 : q_idx + PW'(1);
                wrap  <= (q_idx == idx_last);
            end else begin
                phase <= (q_idx == '0) ? idx_last : q_idx - PW'(1);
                wrap  <= (q_idx == '0);
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_counter.sv
// Bench for shift_seq_counter: directed scenarios then random traffic, all
// checked against a sequence-index model of the counter.
`timescale 1ns/1ps
module tb_shift_seq_counter;

    localparam int W  = 4;
    localparam int PW = $clog2(2*W);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          dir = 1'b0;
    logic          mode = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [W-1:0]  q;
    logic [PW-1:0] phase;
    logic          wrap;
    logic          err;
    logic [W-1:0]  upset_val = '0;

    int   n_checks = 0;
    int   n_fail = 0;
    int   m_mode = 0;
    int   m_idx = 0;
    logic m_wrap = 1'b0;
    logic m_err = 1'b0;

    shift_seq_counter #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .phase    (phase),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic int seq_len(input int md);
        return (md != 0) ? W : 2*W;
    endfunction

    // Value at position k of the sequence: ring is a walking one, Johnson fills
    // ones from the bottom then empties them from the bottom.
    function automatic logic [W-1:0] seq_val(input int md, input int k);
        int v;
        if (md != 0)     v = 1 << k;
        else if (k <= W) v = (1 << k) - 1;
        else             v = ((1 << W) - 1) & ~((1 << (k - W)) - 1);
        return W'(v);
    endfunction

    function automatic int find_idx(input int md, input logic [W-1:0] v);
        for (int k = 0; k < seq_len(md); k++)
            if (seq_val(md, k) == v) return k;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".q"},     32'(q),     32'(seq_val(m_mode, m_idx)));
        chk({tag, ".phase"}, 32'(phase), 32'(m_idx));
        chk({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
        chk({tag, ".err"},   32'(err),   32'(m_err));
    endtask

    task automatic step(input string tag, input logic r, input logic md, input logic ld,
                        input logic [W-1:0] lv, input logic e, input logic d);
        int k;
        int n;
        @(negedge clk);
        reset = r; mode = md; load = ld; load_val = lv; en = e; dir = d;
        @(posedge clk);
        #1;
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (r || (int'(md) != m_mode)) begin
            m_mode = int'(md);
            m_idx  = 0;
        end else if (ld) begin
            k = find_idx(m_mode, lv);
            if (k < 0) m_err = 1'b1;
            else       m_idx = k;
        end else if (e) begin
            n = seq_len(m_mode);
            if (d) begin
                m_wrap = (m_idx == n - 1);
                m_idx  = (m_idx + 1) % n;
            end else begin
                m_wrap = (m_idx == 0);
                m_idx  = (m_idx + n - 1) % n;
            end
        end
        chk_model(tag);
    endtask

    // Corrupts q between edges; the next edge must reseed and flag err.
    task automatic upset(input string tag, input logic [W-1:0] bad);
        @(negedge clk);
        reset = 1'b0; load = 1'b1; load_val = seq_val(m_mode, 1); en = 1'b1; dir = 1'b1;
        upset_val = bad;
        force dut.q = upset_val;
        #1 release dut.q;
        @(posedge clk);
        #1;
        m_idx  = 0;
        m_wrap = 1'b0;
        m_err  = 1'b1;
        chk_model(tag);
    endtask

    initial begin
        step("rst_j", 1, 0, 0, '0, 0, 0);
        chk("rst_j.q_lit", 32'(q), 32'h0);
        repeat (8) step("j_up", 0, 0, 0, '0, 1, 1);
        chk("j_up_end.q_lit", 32'(q), 32'h0);
        chk("j_up_end.wrap_lit", 32'(wrap), 32'h1);
        step("j_dn0", 0, 0, 0, '0, 1, 0);
        chk("j_dn0.q_lit", 32'(q), 32'h8);
        chk("j_dn0.phase_lit", 32'(phase), 32'd7);
        step("j_dn1", 0, 0, 0, '0, 1, 0);
        chk("j_dn1.q_lit", 32'(q), 32'hC);

        step("rst_r", 1, 1, 0, '0, 0, 0);
        chk("rst_r.q_lit", 32'(q), 32'h1);
        repeat (4) step("r_up", 0, 1, 0, '0, 1, 1);
        chk("r_up_end.wrap_lit", 32'(wrap), 32'h1);
        step("r_dn", 0, 1, 0, '0, 1, 0);
        chk("r_dn.q_lit", 32'(q), 32'h8);
        chk("r_dn.phase_lit", 32'(phase), 32'd3);

        step("rst_j2", 1, 0, 0, '0, 0, 0);
        step("ld_ok", 0, 0, 1, 4'b1100, 1, 1);
        chk("ld_ok.phase_lit", 32'(phase), 32'd6);
        step("ld_bad", 0, 0, 1, 4'b0101, 1, 0);
        chk("ld_bad.q_lit", 32'(q), 32'hC);
        chk("ld_bad.err_lit", 32'(err), 32'h1);
        step("ld_bad_after", 0, 0, 0, '0, 0, 0);
        step("ld_0111", 0, 0, 1, 4'b0111, 0, 0);
        step("mode_sw", 0, 1, 1, 4'b0100, 1, 1);
        chk("mode_sw.q_lit", 32'(q), 32'h1);
        repeat (3) step("r_after_sw", 0, 1, 0, '0, 1, 1);
        step("rst_mid", 1, 1, 1, 4'b0100, 1, 1);
        chk("rst_mid.q_lit", 32'(q), 32'h1);

        upset("upset_r", 4'b0110);
        chk("upset_r.q_lit", 32'(q), 32'h1);
        step("to_j", 0, 0, 0, '0, 1, 1);
        step("j_go", 0, 0, 0, '0, 1, 1);
        upset("upset_j", 4'b0101);

        for (int i = 0; i < 400; i++) begin
            logic         r, md, ld, e, d;
            logic [W-1:0] lv;
            r  = ($urandom_range(0, 39) == 0);
            if (r) md = 1'($urandom_range(0, 1));
            else   md = ($urandom_range(0, 24) == 0) ? ~1'(m_mode) : 1'(m_mode);
            ld = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1)
                lv = seq_val(m_mode, int'($urandom_range(0, seq_len(m_mode) - 1)));
            else
                lv = W'($urandom);
            e  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            step("rand", r, md, ld, lv, e, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
